// File: rtl/ase_rsp_egress_pacer.sv
// Pops matured scoreboard entries into a skid FIFO and paces them out on the AFU
// response channel with a valid/ready handshake and an optional idle gap after each beat.
module ase_rsp_egress_pacer #(
  parameter int HDR_WIDTH  = 72,
  parameter int DATA_WIDTH = 72,
  parameter int SKID_DEPTH = 4,
  parameter int MIN_GAP    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sb_empty,
  output logic                  sb_read_en,
  input  logic                  sb_valid_out,
  input  logic [HDR_WIDTH-1:0]  sb_meta_out,
  input  logic [DATA_WIDTH-1:0] sb_data_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [HDR_WIDTH-1:0]  rsp_meta,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [31:0]           rsp_count,
  output logic                  err_unexpected,
  output logic                  err_overflow
);

  localparam int AW = $clog2(SKID_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] DEPTH_L = OW'(SKID_DEPTH);
  localparam logic [7:0]    GAP_L   = 8'(MIN_GAP);

  typedef struct packed {
    logic [HDR_WIDTH-1:0]  meta;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  entry_t        mem [SKID_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ, occ_next;
  logic          pending;
  logic          run;
  logic          push, pop;
  state_t        state;
  logic [7:0]    gap_cnt;

  assign push     = sb_valid_out && (occ < DEPTH_L);
  assign pop      = rsp_valid && rsp_ready;
  assign occ_next = occ + OW'(push) - OW'(pop);

  // Credit counts the pop whose data lands this cycle, so the FIFO is never over-committed.
  // run keeps the pop request low while reset is asserted.
  assign sb_read_en = run && !sb_empty && ((occ + OW'(pending)) < DEPTH_L);

  assign rsp_meta = mem[rd_ptr].meta;
  assign rsp_data = mem[rd_ptr].data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run            <= 1'b0;
      pending        <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occ            <= '0;
      err_unexpected <= 1'b0;
      err_overflow   <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else begin
      run     <= 1'b1;
      pending <= sb_read_en;
      occ     <= occ_next;
      if (sb_valid_out && !pending) err_unexpected <= 1'b1;
      if (sb_valid_out && !push)    err_overflow   <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= '{meta: sb_meta_out, data: sb_data_out};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      gap_cnt   <= '0;
      rsp_count <= '0;
    end else begin
      case (state)
        IDLE: if (occ != '0) begin
          state     <= SEND;
          rsp_valid <= 1'b1;
        end
        SEND: if (rsp_ready) begin
          rsp_count <= rsp_count + 32'd1;
          if (MIN_GAP > 0) begin
            state     <= GAP;
            rsp_valid <= 1'b0;
            gap_cnt   <= GAP_L - 8'd1;
          end else if (occ_next == '0) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            if (occ != '0) begin
              state     <= SEND;
              rsp_valid <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
